// File: rtl/Public_Info.sv
// Shared pipeline types: the decoded instruction record and issue-buffer sizing.
package Public_Info;

  localparam int unsigned IBUF_DEPTH = 8;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 32;

  typedef struct packed {
    logic               o_valid;
    logic [PC_W-1:0]    PC;
    logic [INSTR_W-1:0] instr;
  } PC_set;

  // Dispatch never consumes more than two entries; 3 is read as 2.
  function automatic logic [1:0] clamp_use(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/issue_buffer_ram.sv
// Issue-buffer storage: two adjacent write ports and two adjacent async read ports.
module issue_buffer_ram
  import Public_Info::*;
#(
  parameter  int unsigned DEPTH = IBUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we1_i,
  input  logic             we2_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  PC_set            wdata1_i,
  input  PC_set            wdata2_i,
  input  logic [PTR_W-1:0] raddr_i,
  output PC_set            rdata1_o,
  output PC_set            rdata2_o
);

  PC_set            mem_q [DEPTH];
  logic [PTR_W-1:0] waddr2;
  logic [PTR_W-1:0] raddr2;

  // Pointer+1 wraps naturally at DEPTH (power of two).
  assign waddr2 = waddr_i + PTR_W'(1);
  assign raddr2 = raddr_i + PTR_W'(1);

  // Payload is intentionally not reset; validity is tracked by the top.
  always_ff @(posedge clk) begin
    if (we1_i) mem_q[waddr_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2]  <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr_i];
  assign rdata2_o = mem_q[raddr2];

endmodule

// File: rtl/issue_buffer.sv
// Decode-to-dispatch dual-entry instruction queue with flush and back-pressure.
// Optional IBUF_BYPASS_EN: zero-latency path from i_set* to o_set* when nearly empty.
module issue_buffer
  import Public_Info::*;
#(
  parameter  int unsigned DEPTH = IBUF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  input  PC_set          i_set1,
  input  PC_set          i_set2,
  input  logic [1:0]     i_usingNUM,
  output PC_set          o_set1,
  output PC_set          o_set2,
  output logic           o_stall,
  output logic [PTR_W:0] o_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;

  logic [1:0] push_n;
  logic [1:0] want_n;
  logic [1:0] vis_mem;
  logic [1:0] vis_byp;
  logic [1:0] pop_n;
  logic [1:0] pop_mem;
  logic [1:0] pop_byp;

  logic  we1, we2;
  PC_set wdata1;
  PC_set rd1, rd2;

  // Push qualification: set2 alone never counts, and a stalled cycle drops both.
  always_comb begin
    push_n = 2'd0;
    if (!stall_q && i_set1.o_valid) begin
      push_n = i_set2.o_valid ? 2'd2 : 2'd1;
    end
  end

  assign want_n  = clamp_use(i_usingNUM);
  assign vis_mem = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];

`ifdef IBUF_BYPASS_EN
  // Entries offered straight from decode fill whichever output slots storage leaves empty.
  always_comb begin
    vis_byp = 2'd0;
    if (count_q == CNT_W'(0)) begin
      vis_byp = push_n;
    end else if (count_q == CNT_W'(1)) begin
      vis_byp = (push_n != 2'd0) ? 2'd1 : 2'd0;
    end
  end
`else
  assign vis_byp = 2'd0;
`endif

  // Pops drain stored entries first, then any bypassed ones; clamped to what is visible.
  always_comb begin
    pop_n   = 2'd0;
    pop_mem = 2'd0;
    pop_byp = 2'd0;
    if (!flush) begin
      pop_n   = min2(want_n, vis_mem + vis_byp);
      pop_mem = min2(pop_n, vis_mem);
      pop_byp = pop_n - pop_mem;
    end
  end

  // Inputs already consumed through the bypass are not written; survivors pack at tail.
  always_comb begin
    we1    = 1'b0;
    we2    = 1'b0;
    wdata1 = i_set1;
    if (!flush) begin
      we1 = (push_n > pop_byp);
      we2 = (push_n == 2'd2) && (pop_byp == 2'd0);
      if (pop_byp != 2'd0) wdata1 = i_set2;
    end
  end

  issue_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .we1_i    (we1),
    .we2_i    (we2),
    .waddr_i  (tail_q),
    .wdata1_i (wdata1),
    .wdata2_i (i_set2),
    .raddr_i  (head_q),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Next-state for pointers, occupancy and the conservative (no pop credit) stall.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_mem);
      tail_d  = tail_q + PTR_W'(push_n - pop_byp);
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      stall_d = (count_d >= CNT_W'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  // Output presentation; flush masks validity in the same cycle.
  always_comb begin
    o_set1         = rd1;
    o_set2         = rd2;
    o_set1.o_valid = !flush && (count_q >= CNT_W'(1));
    o_set2.o_valid = !flush && (count_q >= CNT_W'(2));
`ifdef IBUF_BYPASS_EN
    if (count_q == CNT_W'(0)) begin
      o_set1         = i_set1;
      o_set2         = i_set2;
      o_set1.o_valid = !flush && (push_n != 2'd0);
      o_set2.o_valid = !flush && (push_n == 2'd2);
    end else if (count_q == CNT_W'(1)) begin
      o_set2         = i_set1;
      o_set2.o_valid = !flush && (push_n != 2'd0);
    end
`endif
  end

  assign o_stall = stall_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_issue_buffer.sv
// Directed table-driven bench for issue_buffer (DEPTH=8) plus flush/reset/latency sequences.
module tb_issue_buffer;
  import Public_Info::*;

  logic       clk;
  logic       rstn;
  logic       flush;
  PC_set      i_set1, i_set2;
  logic [1:0] i_usingNUM;
  PC_set      o_set1, o_set2;
  logic       o_stall;
  logic [3:0] o_count;

  int errors = 0;
  int checks = 0;

  issue_buffer #(.DEPTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .i_set1     (i_set1),
    .i_set2     (i_set2),
    .i_usingNUM (i_usingNUM),
    .o_set1     (o_set1),
    .o_set2     (o_set2),
    .o_stall    (o_stall),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fl;
    logic        v1;
    logic        v2;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [1:0]  un;
    logic [3:0]  ecnt;
    logic        est;
    logic        ev1;
    logic        ev2;
    logic [31:0] ep1;
    logic [31:0] ep2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic v1, logic v2, logic [31:0] p1, logic [31:0] p2,
                              logic [1:0] un, logic [3:0] ecnt, logic est, logic ev1, logic ev2,
                              logic [31:0] ep1, logic [31:0] ep2);
    vec_t v;
    v.fl = fl; v.v1 = v1; v.v2 = v2; v.p1 = p1; v.p2 = p2; v.un = un;
    v.ecnt = ecnt; v.est = est; v.ev1 = ev1; v.ev2 = ev2; v.ep1 = ep1; v.ep2 = ep2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic v1, input logic v2,
                       input logic [31:0] p1, input logic [31:0] p2, input logic [1:0] un);
    flush          = fl;
    i_set1.o_valid = v1;
    i_set1.PC      = p1;
    i_set1.instr   = ~p1;
    i_set2.o_valid = v2;
    i_set2.PC      = p2;
    i_set2.instr   = ~p2;
    i_usingNUM     = un;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
  endtask

  // Drive for one edge, then return inputs to idle so checks see registered state only.
  task automatic step(input logic fl, input logic v1, input logic v2,
                      input logic [31:0] p1, input logic [31:0] p2, input logic [1:0] un);
    @(negedge clk);
    drive(fl, v1, v2, p1, p2, un);
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] ecnt, input logic est,
                             input logic ev1, input logic ev2,
                             input logic [31:0] ep1, input logic [31:0] ep2);
    check({tag, " count"}, 32'(o_count), 32'(ecnt));
    check({tag, " stall"}, 32'(o_stall), 32'(est));
    check({tag, " v1"}, 32'(o_set1.o_valid), 32'(ev1));
    check({tag, " v2"}, 32'(o_set2.o_valid), 32'(ev2));
    if (ev1) check({tag, " pc1"}, o_set1.PC, ep1);
    if (ev2) check({tag, " pc2"}, o_set2.PC, ep2);
    if (ev1) check({tag, " instr1"}, o_set1.instr, ~ep1);
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_state("reset", 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fill by pairs, stall at full, flush with a push pending.
    vecs.push_back(mk(0,1,1,32'h1c000000,32'h1c000004,0, 2,0,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'h1c000008,32'h1c00000c,0, 4,0,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'h1c000010,32'h1c000014,0, 6,0,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'h1c000018,32'h1c00001c,0, 8,1,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'hdead0000,32'hbeef0000,0, 8,1,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(1,1,1,32'hdead0000,32'hbeef0000,2, 0,0,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,0,               0,0,0,0,32'h0,32'h0));
    // Program order across the 7->0 wrap with mixed pops and refills.
    vecs.push_back(mk(0,1,1,32'h1c000000,32'h1c000004,0, 2,0,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'h1c000008,32'h1c00000c,0, 4,0,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'h1c000010,32'h1c000014,0, 6,0,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,1,1,32'h1c000018,32'h1c00001c,0, 8,1,1,1,32'h1c000000,32'h1c000004));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,1,               7,1,1,1,32'h1c000004,32'h1c000008));
    vecs.push_back(mk(0,1,0,32'hdead0004,32'h0,2,        5,0,1,1,32'h1c00000c,32'h1c000010));
    vecs.push_back(mk(0,1,1,32'h1c000020,32'h1c000024,1, 6,0,1,1,32'h1c000010,32'h1c000014));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,2,               4,0,1,1,32'h1c000018,32'h1c00001c));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,1,               3,0,1,1,32'h1c00001c,32'h1c000020));
    vecs.push_back(mk(0,1,1,32'h1c000028,32'h1c00002c,2, 3,0,1,1,32'h1c000024,32'h1c000028));
    vecs.push_back(mk(0,1,1,32'h1c000030,32'h1c000034,0, 5,0,1,1,32'h1c000024,32'h1c000028));
    vecs.push_back(mk(0,1,0,32'h1c000038,32'h0,2,        4,0,1,1,32'h1c00002c,32'h1c000030));
    vecs.push_back(mk(0,1,1,32'h1c00003c,32'h1c000040,2, 4,0,1,1,32'h1c000034,32'h1c000038));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,2,               2,0,1,1,32'h1c00003c,32'h1c000040));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,2,               0,0,0,0,32'h0,32'h0));
    // Lone set2 is not a push; pop clamping and usingNUM=3.
    vecs.push_back(mk(0,0,1,32'h0,32'hdead0008,0,        0,0,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,0,32'h1c000100,32'h0,0,        1,0,1,0,32'h1c000100,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,2,               0,0,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,2,               0,0,0,0,32'h0,32'h0));
    vecs.push_back(mk(0,1,1,32'h1c000104,32'h1c000108,0, 2,0,1,1,32'h1c000104,32'h1c000108));
    vecs.push_back(mk(0,0,0,32'h0,32'h0,3,               0,0,0,0,32'h0,32'h0));

    foreach (vecs[k]) begin
      step(vecs[k].fl, vecs[k].v1, vecs[k].v2, vecs[k].p1, vecs[k].p2, vecs[k].un);
      check_state($sformatf("vec%0d", k), vecs[k].ecnt, vecs[k].est,
                  vecs[k].ev1, vecs[k].ev2, vecs[k].ep1, vecs[k].ep2);
    end

    // Flush masks output valids in the same cycle, before the edge.
    step(0, 1, 1, 32'h1c000200, 32'h1c000204, 0);
    check_state("preflush", 4'd2, 1'b0, 1'b1, 1'b1, 32'h1c000200, 32'h1c000204);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    #1;
    check("flush comb v1", 32'(o_set1.o_valid), 32'd0);
    check("flush comb v2", 32'(o_set2.o_valid), 32'd0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check_state("postflush", 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-operation.
    step(0, 1, 1, 32'h1c000300, 32'h1c000304, 0);
    step(0, 1, 1, 32'h1c000308, 32'h1c00030c, 0);
    check("prereset count", 32'(o_count), 32'd4);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_state("async rst", 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_state("post rst", 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Latency through an empty buffer with dispatch ready for both.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h1c000040, 32'h1c000044, 2'd2);
    #1;
`ifdef IBUF_BYPASS_EN
    check("byp same v1", 32'(o_set1.o_valid), 32'd1);
    check("byp same v2", 32'(o_set2.o_valid), 32'd1);
    check("byp same pc1", o_set1.PC, 32'h1c000040);
    check("byp same pc2", o_set2.PC, 32'h1c000044);
    @(posedge clk);
    #1;
    idle();
    #1;
    check_state("byp after", 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`else
    check("lat same v1", 32'(o_set1.o_valid), 32'd0);
    check("lat same v2", 32'(o_set2.o_valid), 32'd0);
    @(posedge clk);
    #1;
    idle();
    #1;
    check_state("lat after", 4'd2, 1'b0, 1'b1, 1'b1, 32'h1c000040, 32'h1c000044);
    step(0, 0, 0, 32'h0, 32'h0, 2);
    check_state("lat drain", 4'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- Dual-entry-per-cycle instruction queue between the decode stage and the dual-issue dispatch stage.
- Accepts 0/1/2 decoded `PC_set` entries per cycle from decode.
- Presents the two oldest entries to dispatch and retires 0/1/2 of them per cycle according to dispatch's `usingNUM` feedback.
- Absorbs dispatch single-issue cycles, generates decode back-pressure and handles pipeline flush.

Parameters:
- DEPTH, 8, number of `PC_set` entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous reset, active low
- flush  input  1  discard all contents (branch mispredict / exception)
- i_set1  input  PC_set  older decoded instruction; `.o_valid` qualifies
- i_set2  input  PC_set  younger decoded instruction; `.o_valid` qualifies
- i_usingNUM  input  2  entries consumed by dispatch this cycle (0/1/2)
- o_set1  output  PC_set  head entry to dispatch
- o_set2  output  PC_set  head+1 entry to dispatch
- o_stall  output  1  to decode: pushes not accepted this cycle
- o_count  output  PTR_W+1  current occupancy

Behaviour:
- Reset (rstn=0, async):
  - head, tail and count clear to 0.
  - o_stall=0; o_set1.o_valid=0; o_set2.o_valid=0.
  - Storage payload is not reset.
- Push qualification:
  - push_n = {i_set1.o_valid & i_set2.o_valid} ? 2 : i_set1.o_valid ? 1 : 0.
  - i_set2 valid with i_set1 invalid is treated as 0 pushes, matching dispatch's 2'b01 rule.
- Back-pressure:
  - o_stall = (DEPTH − count) < 2, registered-state based. Pop credit is not taken (conservative).
  - When o_stall=1 all pushes that cycle are dropped; decode must hold its sets.
- Write ordering:
  - i_set1 is written at tail, i_set2 at tail+1.
  - tail advances by push_n, mod DEPTH (natural wrap of the PTR_W pointer).
- Output presentation:
  - o_set1 = mem[head]; o_set1.o_valid = (count ≥ 1).
  - o_set2 = mem[head+1 mod DEPTH]; o_set2.o_valid = (count ≥ 2).
  - All other fields pass through from storage.
- Pop:
  - pop_n = min(i_usingNUM, number of valid outputs). Over-pop is clamped, never underflows.
  - i_usingNUM=3 is treated as 2.
  - head advances by pop_n.
- Count update:
  - count_next = count + push_n − pop_n on the same edge.
  - Simultaneous push and pop are both honoured.
- Latency:
  - An entry pushed at edge N is visible on o_set* after edge N (1 cycle) when bypass is disabled.
- Flush:
  - Highest priority. head, tail and count clear to 0 at the next edge.
  - Pushes and pops in the flush cycle are ignored.
  - o_set1.o_valid and o_set2.o_valid are forced 0 combinationally during the flush cycle.
- Boundaries:
  - Full (count=DEPTH): o_stall=1, pushes dropped.
  - count=DEPTH−1: o_stall=1 even for a single push.
  - Empty: both outputs invalid; any i_usingNUM is ignored.
  - Wrap: a two-entry write/read straddling index DEPTH−1 → 0 must keep order.
- Reset mid-operation: contents are lost; behaviour matches power-up.

Optional Feature:
- Macro: IBUF_BYPASS_EN.
- Defined:
  - When count=0 and flush=0, o_set1/o_set2 are driven combinationally from i_set1/i_set2, with valids equal to the qualified push valids.
  - Entries consumed by i_usingNUM in that same cycle are not written: tail advances by push_n − pop_n; count is unchanged by the consumed ones.
  - When count=1, o_set2 bypasses from i_set1.
  - Zero-cycle latency through an empty buffer.
- Not defined: strict 1-cycle latency as above; no combinational path from i_set* to o_set*.

Decomposition:
- Public_Info package: `PC_set` struct (existing) and new constant IBUF_DEPTH=8, used as the parameter default at instantiation.
- Sub-module issue_buffer_ram: DEPTH×PC_set storage with 2 write ports (waddr, waddr+1, we1/we2) and 2 asynchronous read ports (raddr, raddr+1). The top holds pointers, count, stall and bypass logic.

Test Plan:
- Reset, then push 2 per cycle for 3 cycles with i_usingNUM=0 → count 2,4,6; o_stall rises when count=6 (free=2? no: stall only when free<2) → stall at count=7/8 only; a 4th double push makes count=8 and o_stall=1.
- Fill to 8, pulse flush with i_set1/i_set2 valid → next cycle count=0, o_stall=0, both o_valid=0; the flush-cycle push is not stored.
- Push PCs 0x1c000000..0x1c00001c (8 entries), pop alternating 1 and 2, refill → o_set1.PC follows strict program order across index 7→0 wrap.
- count=1, i_usingNUM=2 → pop clamped to 1, count=0, no underflow; i_usingNUM=2 on empty → count stays 0.
- count=7, push 1 → dropped (o_stall=1), count stays 7; same cycle pop 2 → count=5.
- With IBUF_BYPASS_EN, empty buffer, push PCs 0x1c000040/0x1c000044 with i_usingNUM=2 → outputs show both PCs in the same cycle and count remains 0. Without the macro, outputs show them only on the next cycle.
